// File: rtl/uart_receiver.sv
// UART receiver: synchronized line, start-edge detect, mid-bit sampling, LSB-first payload.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point.
module uart_receiver #(
   parameter int DATA_BITS    = 20,
   parameter int CLKS_PER_BIT = 9
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 serialIn,
   output logic [DATA_BITS-1:0] message,
   output logic                 isValid,
   output logic                 framingErr,
   output logic                 busy
);

   localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int BIT_W = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Decisions land one count past the nominal point, so the counter must be able to reach CLKS_PER_BIT.
   localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam int START_PT = HALF + 1;
   localparam int BIT_PT   = CLKS_PER_BIT;
   localparam int RELOAD   = 1;
`else
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int START_PT = HALF;
   localparam int BIT_PT   = CLKS_PER_BIT - 1;
   localparam int RELOAD   = 0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, sync2_q, delay_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] msg_q, msg_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   logic                 fall;
   logic                 sample_bit;
   logic                 start_hit;
   logic                 bit_hit;
   logic                 last_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] hist_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], sync2_q};
      end
   end

   assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
   assign sample_bit = sync2_q;
`endif

   assign fall      = delay_q & ~sync2_q;
   assign start_hit = (cnt_q == CNT_W'(START_PT));
   assign bit_hit   = (cnt_q == CNT_W'(BIT_PT));
   assign last_bit  = (bit_cnt_q == BIT_W'(DATA_BITS - 1));

   // State register and all datapath flops.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         delay_q   <= 1'b1;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         msg_q     <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= serialIn;
         sync2_q   <= sync1_q;
         delay_q   <= sync2_q;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         msg_q     <= msg_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: a hold default ahead of the case keeps every path assigned, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall) state_d = START;
         START:   if (start_hit) state_d = sample_bit ? IDLE : DATA;
         DATA:    if (bit_hit && last_bit) state_d = STOP;
         STOP:    if (bit_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output logic.
   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      msg_d     = msg_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
         end
         START: begin
            if (start_hit) begin
               cnt_d     = CNT_W'(RELOAD);
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_hit) begin
               shift_d   = {sample_bit, shift_q[DATA_BITS-1:1]};
               cnt_d     = CNT_W'(RELOAD);
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         STOP: begin
            if (bit_hit) begin
               cnt_d = '0;
               if (sample_bit) begin
                  msg_d   = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign message    = msg_q;
   assign isValid    = valid_q;
   assign framingErr = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against a frame-level model.
module tb_uart_receiver;

   localparam int DATA_BITS = 20;
   localparam int CPB       = 9;
   localparam int HALF      = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int VOTE = 1;
`else
   localparam int VOTE = 0;
`endif
   localparam int LATENCY = 2 + 1 + HALF + 1 + (DATA_BITS + 1) * CPB + 1 + VOTE;

   logic                 clock    = 1'b0;
   logic                 reset    = 1'b0;
   logic                 serialIn = 1'b1;
   logic [DATA_BITS-1:0] message;
   logic                 isValid;
   logic                 framingErr;
   logic                 busy;

   uart_receiver #(
      .DATA_BITS   (DATA_BITS),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .serialIn  (serialIn),
      .message   (message),
      .isValid   (isValid),
      .framingErr(framingErr),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: records every isValid / framingErr cycle with the context around it.
   typedef struct {
      bit                   is_err;
      logic [DATA_BITS-1:0] msg;
      int                   cyc;
      logic                 busy_now;
      logic                 busy_prev;
   } ev_t;

   ev_t  evq[$];
   logic busy_prev_q = 1'b0;
   bit   busy_seen   = 1'b0;

   always @(negedge clock) begin
      if (isValid || framingErr) begin
         check("strobe_exclusive", 32'(isValid & framingErr), 32'd0);
         evq.push_back('{framingErr, message, cyc, busy, busy_prev_q});
      end
      if (busy) busy_seen = 1'b1;
      busy_prev_q = busy;
   end

   // Model state: the word the receiver should currently present.
   logic [DATA_BITS-1:0] last_good = '0;
   int                   start_cyc = 0;

   // Inputs change 1 time unit after a rising edge.
   task automatic drive(input logic b, input int n);
      serialIn = b;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop,
                             input int glitch_bit, input int abort_bit);
      start_cyc = cyc;
      drive(1'b0, CPB);
      for (int i = 0; i < DATA_BITS; i++) begin
         if (i == abort_bit) begin
            drive(d[i], HALF);
            return;
         end
         if (i == glitch_bit) begin
            drive(d[i], HALF + 1);
            drive(~d[i], 1);
            drive(d[i], CPB - HALF - 2);
         end else begin
            drive(d[i], CPB);
         end
      end
      drive(stop, CPB);
   endtask

   // A frame with a high stop bit yields one valid strobe carrying the word; a low one yields one
   // framing error and leaves the presented word alone.
   task automatic expect_frame(input string tag, input logic [DATA_BITS-1:0] exp_word, input logic stop);
      ev_t ev;
      drive(1'b1, 4);
      check({tag, "_events"}, evq.size(), 1);
      if (stop) last_good = exp_word;
      if (evq.size() >= 1) begin
         ev = evq[0];
         check({tag, "_is_err"}, 32'(ev.is_err), 32'(!stop));
         check({tag, "_msg"}, ev.msg, last_good);
         check({tag, "_busy_at_strobe"}, ev.busy_now, 1'b0);
         check({tag, "_busy_before"}, ev.busy_prev, 1'b1);
         // Start edge launched just after a clock edge resolves the +/-1 phase to the early side.
         if (stop) check({tag, "_latency"}, ev.cyc - start_cyc, LATENCY - 1);
      end
      check({tag, "_msg_out"}, message, last_good);
      evq.delete();
   endtask

   initial begin
      logic [DATA_BITS-1:0] d;
      logic                 st;

      // Reset state
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check("rst_message", message, '0);
      check("rst_isValid", isValid, 1'b0);
      check("rst_framingErr", framingErr, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b1;
      drive(1'b1, 5);
      evq.delete();

      // Basic frame
      send_frame(20'hA5A5C, 1'b1, -1, -1);
      expect_frame("basic", 20'hA5A5C, 1'b1);

      // Short low glitch on an idle line is a false start
      busy_seen = 1'b0;
      drive(1'b0, 3);
      drive(1'b1, 3 * CPB);
      check("glitch_busy_seen", busy_seen, 1'b1);
      check("glitch_no_strobe", evq.size(), 0);
      check("glitch_busy_idle", busy, 1'b0);
      check("glitch_msg", message, last_good);
      evq.delete();

      // Stop bit driven low
      send_frame(20'h12345, 1'b0, -1, -1);
      expect_frame("ferr", 20'h12345, 1'b0);

      // Back-to-back frames with no idle gap
      send_frame(20'h00001, 1'b1, -1, -1);
      send_frame(20'hFFFFF, 1'b1, -1, -1);
      drive(1'b1, 4);
      check("b2b_events", evq.size(), 2);
      if (evq.size() == 2) begin
         check("b2b_first_msg", evq[0].msg, 20'h00001);
         check("b2b_first_err", 32'(evq[0].is_err), 32'd0);
         check("b2b_second_msg", evq[1].msg, 20'hFFFFF);
         check("b2b_second_err", 32'(evq[1].is_err), 32'd0);
      end
      last_good = 20'hFFFFF;
      check("b2b_msg_out", message, last_good);
      evq.delete();

      // Reset during data bit 10, then a clean frame
      send_frame(20'h3C3C3, 1'b1, -1, 10);
      serialIn = 1'b1;
      reset    = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_message", message, '0);
      check("midrst_isValid", isValid, 1'b0);
      @(posedge clock);
      #1;
      reset     = 1'b1;
      last_good = '0;
      drive(1'b1, 2 * CPB);
      check("midrst_no_strobe", evq.size(), 0);
      check("midrst_msg_hold", message, '0);
      evq.delete();
      send_frame(20'h0F0F0, 1'b1, -1, -1);
      expect_frame("post_rst", 20'h0F0F0, 1'b1);

      // One-cycle inverted glitch at the mid-sample of data bit 3
      send_frame(20'h00000, 1'b1, 3, -1);
      expect_frame("midglitch", (VOTE != 0) ? 20'h00000 : 20'h00008, 1'b1);

      // Line held low: one framing error, no retrigger on constant low
      drive(1'b0, 3 * (DATA_BITS + 2) * CPB);
      check("low_events", evq.size(), 1);
      if (evq.size() >= 1) check("low_is_err", 32'(evq[0].is_err), 32'd1);
      check("low_busy", busy, 1'b0);
      check("low_msg", message, last_good);
      drive(1'b1, 2 * CPB);
      evq.delete();

      // Random frames with random stop bits and idle gaps
      for (int r = 0; r < 10; r++) begin
         d  = DATA_BITS'($urandom);
         st = ($urandom_range(0, 3) != 0);
         send_frame(d, st, -1, -1);
         expect_frame("rand", d, st);
         drive(1'b1, $urandom_range(0, 2 * CPB));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver, the far end of the team's 22-bit-frame serial link. Each frame is 1 start bit (0), DATA_BITS data bits sent LSB first, then 1 stop bit (1). The block synchronizes the raw line, detects the start edge and samples each bit at mid-period. It presents the recovered word with a one-cycle valid strobe, or flags a framing error.

Parameters:
DATA_BITS, 20, payload width per frame.
CLKS_PER_BIT, 9, clock cycles per serial bit period (minimum 4).

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising edge of clock.
serialIn  input  1  raw asynchronous serial line; idles high.
message  output  DATA_BITS  last correctly received word.
isValid  output  1  one-cycle pulse: message has just been updated.
framingErr  output  1  one-cycle pulse: stop bit sampled as 0.
busy  output  1  high while a frame is in progress (any state but IDLE).

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; message=0; isValid=0; framingErr=0; busy=0; shift register=0; counters=0; synchronizer flops=1 (line idle).
- Input path: 2-flop synchronizer on serialIn, plus one delayed copy for edge detection. Falling edge = delayed copy 1 and synchronized value 0.
- HALF = (CLKS_PER_BIT-1)/2 (integer division). Sample counter width = $clog2(CLKS_PER_BIT). Bit counter width = $clog2(DATA_BITS+1).
- IDLE: on falling edge, go to START with the sample counter cleared to 0. Otherwise hold.
- START: counter increments each cycle. When counter==HALF, sample the line.
  - Sample 0: go to DATA, clear the sample counter and the bit counter.
  - Sample 1: false start; return to IDLE, with no strobe.
- DATA: counter increments each cycle. When counter==CLKS_PER_BIT-1, sample the line, shift it in at the MSB (right shift, so the first bit received ends in bit 0), clear the counter and increment the bit counter. After DATA_BITS samples, go to STOP.
- STOP: when counter==CLKS_PER_BIT-1, sample the line.
  - Sample 1: message <= shift register; isValid=1 for the next cycle only.
  - Sample 0: framingErr=1 for the next cycle only; message unchanged.
  - Either way, go to IDLE on the same edge.
- Back-to-back frames: IDLE is entered at the stop-bit mid-sample, so a start edge half a bit later is accepted.
- isValid and framingErr are never high together.
- Falling edges in START, DATA or STOP are ignored.
- Latency: isValid rises 2 (synchronizer) + 1 (edge detect) + HALF + 1 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the start-bit falling edge on serialIn, ±1 for input phase.
- Reset asserted mid-frame: the frame is abandoned immediately with no strobe; message returns to 0.
- Line held low indefinitely: each frame ends in framingErr. The receiver waits in IDLE for the next high-to-low edge and does not retrigger on a constant low.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: every bit decision (start, data, stop) is the 2-of-3 majority of the synchronized line at counter values S-1, S and S+1. S = HALF in START and CLKS_PER_BIT-1 in DATA/STOP. The decision and state transition occur at S+1. Sampling timing is otherwise as above, so overall latency grows by 1 cycle.
- Not defined: single sample at S, exactly as in Behaviour; no extra logic.

Test Plan:
- Send 20'hA5A5C framed (start 0, LSB first, stop 1) at 9 clocks/bit -> message=20'hA5A5C; isValid high exactly 1 cycle; framingErr stays 0; busy falls the cycle isValid rises.
- Two frames, 20'h00001 then 20'hFFFFF, with no idle gap between stop bit and next start bit -> two isValid pulses; message=20'h00001 then 20'hFFFFF.
- 3-cycle low glitch on idle line -> busy pulses high; returns to IDLE at HALF; no isValid, no framingErr; message unchanged.
- Frame 20'h12345 with stop bit driven 0 -> framingErr 1-cycle pulse; isValid 0; message keeps prior value (20'hA5A5C from earlier frame).
- Assert reset (0) during data bit 10 of a frame, release 2 cycles later, then send 20'h0F0F0 -> busy=0 and message=0 during reset; next frame received correctly with no spurious strobe from the aborted one.
- 1-cycle inverted glitch at the mid-sample of data bit 3 of 20'h00000 -> with UART_RX_MAJORITY_VOTE_EN: message=20'h00000; without it: message=20'h00008.
